// File: rtl/mem_request_arbiter.sv
// Round-robin arbiter that funnels NUM_CONSUMERS LSU read/write requests onto one
// data-memory channel, one transaction at a time, and relays completion back.
module mem_request_arbiter #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_CONSUMERS-1:0]             consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]             consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]             consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]             consumer_write_ready,
  output logic                                 mem_read_valid,
  output logic [ADDR_BITS-1:0]                 mem_read_address,
  input  logic                                 mem_read_ready,
  input  logic [DATA_BITS-1:0]                 mem_read_data,
  output logic                                 mem_write_valid,
  output logic [ADDR_BITS-1:0]                 mem_write_address,
  output logic [DATA_BITS-1:0]                 mem_write_data,
  input  logic                                 mem_write_ready
);

  localparam int PTR_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam int SUM_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [SUM_W-1:0] sum_t;

  localparam sum_t NC       = sum_t'(NUM_CONSUMERS);
  localparam ptr_t LAST_IDX = ptr_t'(NUM_CONSUMERS - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ_WAITING,
    WRITE_WAITING,
    READ_RELAY,
    WRITE_RELAY
  } state_t;

  state_t state_q, state_d;
  ptr_t   rr_ptr_q, rr_ptr_d;
  ptr_t   grant_q, grant_d;

  logic                               mem_read_valid_d;
  logic [ADDR_BITS-1:0]               mem_read_address_d;
  logic                               mem_write_valid_d;
  logic [ADDR_BITS-1:0]               mem_write_address_d;
  logic [DATA_BITS-1:0]               mem_write_data_d;
  logic [NUM_CONSUMERS-1:0]           consumer_read_ready_d;
  logic [NUM_CONSUMERS-1:0]           consumer_write_ready_d;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data_d;

  logic found;
  ptr_t pick;
  sum_t sum;
  ptr_t cand;

  // First requester at or after rr_ptr, wrapping; ties within a consumer go to read.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_CONSUMERS; k++) begin
      sum = sum_t'(rr_ptr_q) + sum_t'(k);
      if (sum >= NC) sum = sum - NC;
      cand = ptr_t'(sum);
      if (!found && (consumer_read_valid[cand] || consumer_write_valid[cand])) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // NOTE: every signal written here gets its hold value first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d                = state_q;
    rr_ptr_d               = rr_ptr_q;
    grant_d                = grant_q;
    mem_read_valid_d       = mem_read_valid;
    mem_read_address_d     = mem_read_address;
    mem_write_valid_d      = mem_write_valid;
    mem_write_address_d    = mem_write_address;
    mem_write_data_d       = mem_write_data;
    consumer_read_ready_d  = consumer_read_ready;
    consumer_write_ready_d = consumer_write_ready;
    consumer_read_data_d   = consumer_read_data;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          if (consumer_read_valid[pick]) begin
            mem_read_valid_d   = 1'b1;
            mem_read_address_d = consumer_read_address[int'(pick)*ADDR_BITS +: ADDR_BITS];
            state_d            = READ_WAITING;
          end else begin
            mem_write_valid_d   = 1'b1;
            mem_write_address_d = consumer_write_address[int'(pick)*ADDR_BITS +: ADDR_BITS];
            mem_write_data_d    = consumer_write_data[int'(pick)*DATA_BITS +: DATA_BITS];
            state_d             = WRITE_WAITING;
          end
        end
      end
      READ_WAITING: begin
        if (mem_read_ready) begin
          mem_read_valid_d = 1'b0;
          consumer_read_data_d[int'(grant_q)*DATA_BITS +: DATA_BITS] = mem_read_data;
          consumer_read_ready_d          = '0;
          consumer_read_ready_d[grant_q] = 1'b1;
          state_d                        = READ_RELAY;
        end
      end
      WRITE_WAITING: begin
        if (mem_write_ready) begin
          mem_write_valid_d               = 1'b0;
          consumer_write_ready_d          = '0;
          consumer_write_ready_d[grant_q] = 1'b1;
          state_d                         = WRITE_RELAY;
        end
      end
      READ_RELAY: begin
        if (!consumer_read_valid[grant_q]) begin
          consumer_read_ready_d = '0;
          rr_ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + ptr_t'(1);
          state_d  = IDLE;
        end
      end
      WRITE_RELAY: begin
        if (!consumer_write_valid[grant_q]) begin
          consumer_write_ready_d = '0;
          rr_ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + ptr_t'(1);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q              <= IDLE;
      rr_ptr_q             <= '0;
      grant_q              <= '0;
      mem_read_valid       <= 1'b0;
      mem_read_address     <= '0;
      mem_write_valid      <= 1'b0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
      consumer_read_ready  <= '0;
      consumer_write_ready <= '0;
      consumer_read_data   <= '0;
    end else begin
      state_q              <= state_d;
      rr_ptr_q             <= rr_ptr_d;
      grant_q              <= grant_d;
      mem_read_valid       <= mem_read_valid_d;
      mem_read_address     <= mem_read_address_d;
      mem_write_valid      <= mem_write_valid_d;
      mem_write_address    <= mem_write_address_d;
      mem_write_data       <= mem_write_data_d;
      consumer_read_ready  <= consumer_read_ready_d;
      consumer_write_ready <= consumer_write_ready_d;
      consumer_read_data   <= consumer_read_data_d;
    end
  end

endmodule
